// File: rtl/alu_cmd_seq.sv
// -----------------------------------------------------------------------------
// alu_cmd_seq
//
// Command sequencer in front of a 32-bit combinational ALU.
//
// Operation
// - Commands {a, b, op} are accepted over a valid/ready handshake into an
//   in-order FIFO.
// - One command at a time is issued to the ALU through registered operand and
//   op outputs.
// - The result, {n,z,v,c} flags and error bit are captured after the operands
//   have been stable for one full cycle.
// - The captured response is returned over a second valid/ready handshake.
// - A saturating 8-bit counter records how many error (undefined-op) responses
//   were produced.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_ready = (fifo_count != DEPTH)
//   cmd_a, cmd_b, cmd_op  command operands and ALU op code
//   rsp_valid/rsp_ready   response handshake
//   rsp_s, rsp_flags      captured result and {n,z,v,c}
//   rsp_err               captured ALU error
//   err_count             saturating count of error responses
//   fifo_count            entries currently queued
//   alu_a, alu_b, alu_op  registered ALU inputs
//   alu_s, alu_n..alu_c   ALU result and flags
//   alu_hata              ALU error (undefined op code)
// -----------------------------------------------------------------------------
module alu_cmd_seq #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  // command side
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [31:0]              cmd_a,
  input  logic [31:0]              cmd_b,
  input  logic [3:0]               cmd_op,
  // response side
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_s,
  output logic [3:0]               rsp_flags,
  output logic                     rsp_err,
  // status
  output logic [7:0]               err_count,
  output logic [$clog2(DEPTH):0]   fifo_count,
  // ALU side
  output logic [31:0]              alu_a,
  output logic [31:0]              alu_b,
  output logic [3:0]               alu_op,
  input  logic [31:0]              alu_s,
  input  logic                     alu_n,
  input  logic                     alu_z,
  input  logic                     alu_v,
  input  logic                     alu_c,
  input  logic                     alu_hata
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  cmd_t          head;

  state_t        state_q;
  logic          push;
  logic          pop;

  assign cmd_ready  = (count_q != FULL);
  assign fifo_count = count_q;
  assign head       = mem_q[rd_ptr_q];

  assign push = cmd_valid && cmd_ready;
  // A pop happens when the sequencer is free to issue: idle, or handing off
  // its current response on this very edge.
  assign pop  = (count_q != '0) &&
                ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));

  // NOTE: every signal assigned in a combinational block gets a default first,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage arrays are deliberately left out of reset; only the pointers
  // and count define which entries are meaningful, so clearing the data buys
  // nothing and prevents mapping onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{a: cmd_a, b: cmd_b, op: cmd_op};
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);  // wraps modulo DEPTH
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue / capture sequencer
  // ---------------------------------------------------------------------------
  logic [31:0] alu_a_q;
  logic [31:0] alu_b_q;
  logic [3:0]  alu_op_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_s_q;
  logic [3:0]  rsp_flags_q;
  logic        rsp_err_q;
  logic [7:0]  err_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_s_q     <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            alu_a_q  <= head.a;
            alu_b_q  <= head.b;
            alu_op_q <= head.op;
            state_q  <= EXEC;
          end
        end

        EXEC: begin
          // Operands have been stable for a full cycle; the ALU output is
          // settled. An undefined op yields no meaningful result or flags.
          if (alu_hata) begin
            rsp_s_q     <= '0;
            rsp_flags_q <= '0;
            rsp_err_q   <= 1'b1;
            if (err_count_q != 8'hFF) begin
              err_count_q <= err_count_q + 8'd1;
            end
          end else begin
            rsp_s_q     <= alu_s;
            rsp_flags_q <= {alu_n, alu_z, alu_v, alu_c};
            rsp_err_q   <= 1'b0;
          end
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            // Going straight back to EXEC skips the idle cycle, giving one
            // response every two cycles under continuous demand.
            if (pop) begin
              alu_a_q  <= head.a;
              alu_b_q  <= head.b;
              alu_op_q <= head.op;
              state_q  <= EXEC;
            end else begin
              state_q  <= IDLE;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_s     = rsp_s_q;
  assign rsp_flags = rsp_flags_q;
  assign rsp_err   = rsp_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_seq
//
// Self-checking bench for alu_cmd_seq.
//
// ALU model
// - A small combinational ALU model drives the DUT's ALU inputs from its
//   registered operand outputs.
// - Ops: 0000 add, 1000 sub, 0100 xor, 0011 signed less-than,
//   0010 unsigned greater-than.
// - Every other op raises hata and drives deliberate garbage on the result
//   and flags.
//
// Checks
// - Single commands are driven from a vector table, with latency, operand
//   registers, response contents and error count checked.
// - Hand-written sequences then cover:
//   - error-count saturation,
//   - backpressure and ordering,
//   - reset in mid-operation.
// -----------------------------------------------------------------------------
module tb_alu_cmd_seq;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [3:0]  cmd_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_s;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
  logic [7:0]  err_count;
  logic [2:0]  fifo_count;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_s;
  logic        alu_n;
  logic        alu_z;
  logic        alu_v;
  logic        alu_c;
  logic        alu_hata;

  int n_vec = 0;
  int n_err = 0;
  int exp_ec = 0;

  alu_cmd_seq #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_op    (cmd_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_s     (rsp_s),
    .rsp_flags (rsp_flags),
    .rsp_err   (rsp_err),
    .err_count (err_count),
    .fifo_count(fifo_count),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_s     (alu_s),
    .alu_n     (alu_n),
    .alu_z     (alu_z),
    .alu_v     (alu_v),
    .alu_c     (alu_c),
    .alu_hata  (alu_hata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // ALU model
  // ---------------------------------------------------------------------------
  logic [32:0] alu_t;

  always_comb begin
    alu_t    = '0;
    alu_s    = '0;
    alu_n    = 1'b0;
    alu_z    = 1'b0;
    alu_v    = 1'b0;
    alu_c    = 1'b0;
    alu_hata = 1'b0;
    case (alu_op)
      4'b0000: begin
        alu_t = {1'b0, alu_a} + {1'b0, alu_b};
        alu_s = alu_t[31:0];
        alu_c = alu_t[32];
        alu_v = (alu_a[31] == alu_b[31]) && (alu_s[31] != alu_a[31]);
      end
      4'b1000: begin
        alu_t = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_s = alu_t[31:0];
        alu_c = alu_t[32];
        alu_v = (alu_a[31] != alu_b[31]) && (alu_s[31] != alu_a[31]);
      end
      4'b0100: alu_s = alu_a ^ alu_b;
      4'b0011: alu_s = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'b0010: alu_s = {31'd0, alu_a > alu_b};
      default: begin
        alu_s    = 32'hDEAD_BEEF;
        alu_v    = 1'b1;
        alu_c    = 1'b1;
        alu_hata = 1'b1;
      end
    endcase
    if (!alu_hata) begin
      alu_n = alu_s[31];
      alu_z = (alu_s == 32'd0);
    end else begin
      alu_n = 1'b1;
      alu_z = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  // Offers one command and returns once it has been accepted, with a bound.
  // Called just after a rising edge; returns #1 after the accepting edge.
  task automatic push_cmd(input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op);
    bit ok;
    int n;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_valid = 1'b1;
    ok        = 1'b0;
    n         = 0;
    do begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 100);
    cmd_valid = 1'b0;
    check("push_accepted", 32'(ok), 32'd1);
  endtask

  // Waits for the pipeline to go quiet (empty FIFO, no response) for 3 cycles.
  task automatic drain();
    int quiet;
    quiet = 0;
    for (int i = 0; i < 200 && quiet < 3; i++) begin
      @(posedge clk);
      #1;
      quiet = (fifo_count == 3'd0 && !rsp_valid) ? quiet + 1 : 0;
    end
    check("drain_quiet", 32'(quiet), 32'd3);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] exp_s;
    logic [3:0]  exp_flags;  // {n,z,v,c}
    logic        exp_err;
  } vec_t;

  vec_t vecs [8];

  logic [31:0] got [$];
  bit          acc;

  initial begin
    vecs[0] = '{"add_5_7",     32'd5,          32'd7, 4'b0000, 32'd12,          4'b0000, 1'b0};
    vecs[1] = '{"sub_5_5",     32'd5,          32'd5, 4'b1000, 32'd0,           4'b0101, 1'b0};
    vecs[2] = '{"xor_ff_1",    32'hFFFF_FFFF,  32'd1, 4'b0100, 32'hFFFF_FFFE,   4'b1000, 1'b0};
    vecs[3] = '{"add_ovf",     32'h7FFF_FFFF,  32'd1, 4'b0000, 32'h8000_0000,   4'b1010, 1'b0};
    vecs[4] = '{"add_carry",   32'hFFFF_FFFF,  32'd1, 4'b0000, 32'd0,           4'b0101, 1'b0};
    vecs[5] = '{"slt_signed",  32'hFFFF_FFFF,  32'd1, 4'b0011, 32'd1,           4'b0000, 1'b0};
    vecs[6] = '{"ugt",         32'hFFFF_FFFF,  32'd1, 4'b0010, 32'd1,           4'b0000, 1'b0};
    vecs[7] = '{"undef_op",    32'd9,          32'd3, 4'b1111, 32'd0,           4'b0000, 1'b1};

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_op    = '0;
    rsp_ready = 1'b1;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready",  32'(cmd_ready),  32'd1);
    check("rst_rsp_valid",  32'(rsp_valid),  32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_err_count",  32'(err_count),  32'd0);
    check("rst_alu_a",      alu_a,           32'd0);
    check("rst_rsp_s",      rsp_s,           32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // ---------------- table-driven single commands ----------------
    for (int i = 0; i < 8; i++) begin
      cmd_a     = vecs[i].a;
      cmd_b     = vecs[i].b;
      cmd_op    = vecs[i].op;
      cmd_valid = 1'b1;
      check({vecs[i].name, "_ready"}, 32'(cmd_ready), 32'd1);
      @(posedge clk);                        // edge k: accepted
      #1;
      cmd_valid = 1'b0;
      check({vecs[i].name, "_k_count"}, 32'(fifo_count), 32'd1);
      check({vecs[i].name, "_k_valid"}, 32'(rsp_valid),  32'd0);
      @(posedge clk);                        // edge k+1: popped and issued
      #1;
      check({vecs[i].name, "_alu_a"},   alu_a,            vecs[i].a);
      check({vecs[i].name, "_alu_op"},  32'(alu_op),      32'(vecs[i].op));
      check({vecs[i].name, "_k1_count"}, 32'(fifo_count), 32'd0);
      check({vecs[i].name, "_k1_valid"}, 32'(rsp_valid),  32'd0);
      @(posedge clk);                        // edge k+2: response valid
      #1;
      if (vecs[i].exp_err && exp_ec < 255) exp_ec++;
      check({vecs[i].name, "_valid"},  32'(rsp_valid), 32'd1);
      check({vecs[i].name, "_s"},      rsp_s,          vecs[i].exp_s);
      check({vecs[i].name, "_flags"},  32'(rsp_flags), 32'(vecs[i].exp_flags));
      check({vecs[i].name, "_err"},    32'(rsp_err),   32'(vecs[i].exp_err));
      check({vecs[i].name, "_errcnt"}, 32'(err_count), 32'(exp_ec));
      @(posedge clk);                        // edge k+3: handshake
      #1;
      check({vecs[i].name, "_done"},   32'(rsp_valid), 32'd0);
    end

    // ---------------- error count saturation ----------------
    for (int i = 0; i < 300; i++) begin
      push_cmd(32'(i), 32'd0, 4'b1111);
    end
    drain();
    check("errcnt_saturated", 32'(err_count), 32'd255);

    // ---------------- backpressure and ordering ----------------
    rsp_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      push_cmd(32'(i), 32'd0, 4'b0000);
    end
    check("bp_full_ready", 32'(cmd_ready),  32'd0);
    check("bp_full_count", 32'(fifo_count), 32'd4);
    // Offer the 6th command while full; it must not be taken.
    cmd_a     = 32'd6;
    cmd_b     = 32'd0;
    cmd_op    = 4'b0000;
    cmd_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("bp_hold_count", 32'(fifo_count), 32'd4);
    check("bp_hold_valid", 32'(rsp_valid),  32'd1);
    check("bp_hold_s",     rsp_s,           32'd1);
    check("bp_hold_alu_a", alu_a,           32'd1);
    rsp_ready = 1'b1;
    got.delete();
    for (int cyc = 0; cyc < 60 && got.size() < 6; cyc++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) got.push_back(rsp_s);
      acc = cmd_valid && cmd_ready;
      @(posedge clk);
      #1;
      if (acc) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    check("bp_rsp_total", 32'(got.size()), 32'd6);
    for (int i = 0; i < got.size(); i++) begin
      check($sformatf("bp_order_%0d", i), got[i], 32'(i + 1));
    end
    drain();

    // ---------------- reset mid-operation ----------------
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_cmd(32'(50 + i), 32'd1, 4'b0000);
    end
    check("mid_pre_valid", 32'(rsp_valid),  32'd1);
    check("mid_pre_count", 32'(fifo_count), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(rsp_valid),  32'd0);
    check("mid_rst_count", 32'(fifo_count), 32'd0);
    check("mid_rst_ready", 32'(cmd_ready),  32'd1);
    check("mid_rst_alu_a", alu_a,           32'd0);
    check("mid_rst_errcnt", 32'(err_count), 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    push_cmd(32'd100, 32'd23, 4'b0000);
    got.delete();
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) got.push_back(rsp_s);
    end
    check("mid_post_count", 32'(got.size()), 32'd1);
    if (got.size() > 0) check("mid_post_s", got[0], 32'd123);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_cmd_seq.md
# alu_cmd_seq

Command sequencer that sits in front of the 32-bit combinational ALU and acts as the initiator on its operand/result interface. It accepts operation commands over a valid/ready handshake and buffers them in an in-order FIFO. It issues one command at a time to the ALU from registered operand/op outputs, captures the ALU result, flags and error bit, and returns them over a second valid/ready handshake. It also keeps a saturating count of error (undefined-op) results.

## Interface
- DEPTH, 4, command FIFO entries; power of two, ≥2
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept; equals (fifo count != DEPTH)
- cmd_a  in  32  operand A
- cmd_b  in  32  operand B
- cmd_op  in  4  ALU op code
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer takes response
- rsp_s  out  32  captured result
- rsp_flags  out  4  captured {n,z,v,c}
- rsp_err  out  1  captured ALU error (hata)
- err_count  out  8  number of error responses issued, saturating at 255
- fifo_count  out  $clog2(DEPTH)+1  entries currently in FIFO
- alu_a, alu_b  out  32  registered ALU operands
- alu_op  out  4  registered ALU op
- alu_s  in  32  ALU result
- alu_n, alu_z, alu_v, alu_c  in  1  ALU flags
- alu_hata  in  1  ALU error: undefined op code

## Operation
- FIFO push: on cmd_valid && cmd_ready, push {cmd_a, cmd_b, cmd_op}.
- FIFO pointers wrap modulo DEPTH.
- Simultaneous push and pop leaves fifo_count unchanged.
- When full, cmd_ready=0 and cmd_valid is ignored.
- FSM states are IDLE, EXEC, RESP.
- IDLE:
  - If FIFO non-empty: pop the head, load alu_a/alu_b/alu_op, go to EXEC.
  - Otherwise stay in IDLE.
- EXEC (operands stable one full cycle):
  - Capture rsp_s=alu_s, rsp_flags={alu_n,alu_z,alu_v,alu_c}, rsp_err=alu_hata.
  - Set rsp_valid=1, go to RESP.
- RESP:
  - Hold all rsp_* stable while rsp_valid && !rsp_ready.
  - On rsp_ready, clear rsp_valid.
  - Then, if FIFO non-empty, pop and load the next command, go to EXEC; else go to IDLE.
- Error capture: when alu_hata=1, force rsp_s=0 and rsp_flags=0 (the ALU result is undefined), rsp_err=1.
- err_count increments by 1 in the same cycle as each error capture; it saturates at 255 and never wraps.
- alu_a/alu_b/alu_op keep their last issued value in IDLE and RESP; they change only on a pop.
- Responses return strictly in command acceptance order.
- The pipeline holds at most DEPTH+1 outstanding commands: DEPTH in the FIFO plus 1 in EXEC/RESP.

## Timing
- Reset (asynchronous, active-high):
  - FIFO emptied, pointers 0, state IDLE.
  - rsp_valid=0, rsp_s=0, rsp_flags=0, rsp_err=0, err_count=0, fifo_count=0.
  - alu_a=0, alu_b=0, alu_op=0.
  - cmd_ready=1 during and after reset.
- Reset mid-operation discards all queued and in-flight commands; no response is produced for them.
- Latency, FSM in IDLE and FIFO empty:
  - Command accepted at edge k.
  - Popped and ALU inputs loaded at edge k+1.
  - rsp_valid high after edge k+2.
- Throughput: one response per 2 cycles when rsp_ready is held high. The RESP→EXEC transition saves the IDLE cycle.
- A response handshake and a pop can occur on the same edge.
- A push can occur on that same edge as well.
- cmd_ready is combinational from fifo_count only; it has no dependency on cmd_valid.
- rsp_valid must not drop without rsp_ready.

## Test plan
- Add: a=5, b=7, op=0000 accepted at edge k, rsp_ready=1 → rsp_valid after edge k+2, rsp_s=12, rsp_flags z=0, rsp_err=0.
- Subtract: a=5, b=5, op=1000 → rsp_s=0, z=1. Then a=0xFFFFFFFF, b=0x00000001, op=0100 (xor) → rsp_s=0xFFFFFFFE.
- Undefined op: op=1111 → rsp_err=1, rsp_s=0, rsp_flags=0, err_count=1. Repeat 300 times → err_count=255.
- Backpressure and ordering:
  - Hold rsp_ready=0 and offer 6 adds (a=i, b=0, i=1..6).
  - Expect cmd_ready=0 after 5 accepted (1 in RESP plus 4 in FIFO); rsp_s stays 1 while held.
  - Release rsp_ready → responses 1,2,3,4,5 in order.
  - The 6th command is accepted once space frees and returns 6 last.
- Signed compare: a=0xFFFFFFFF, b=1, op=0011 → rsp_s=1. Same operands with op=0010 → rsp_s=1 (unsigned greater-than).
- Reset mid-operation:
  - Assert reset while in RESP with 3 commands queued.
  - Expect rsp_valid=0, fifo_count=0, cmd_ready=1 immediately.
  - After reset release, a single new command returns only its own result.
